// File: rtl/mvu_pe_acc_seq_if.sv
// Handshake/bus bundle for mvu_pe_acc_seq.
//   in_v / in_rdy     : SIMD beat handshake at the adder-tree input
//   add_out           : adder-tree sum for the beat retiring this cycle
//   out_v / out_rdy   : result handshake
//   out_acc, out_last : accumulated result and end-of-frame flag
//   busy              : any beat in flight, partial sum held, or result pending
// master = upstream/downstream environment, slave = the accumulator.
interface mvu_pe_acc_seq_if #(
    parameter int unsigned TDstI = 16
) ();
    logic             in_v;
    logic             in_rdy;
    logic [TDstI-1:0] add_out;
    logic             out_v;
    logic             out_rdy;
    logic [TDstI-1:0] out_acc;
    logic             out_last;
    logic             busy;

    modport master (
        output in_v, add_out, out_rdy,
        input  in_rdy, out_v, out_acc, out_last, busy
    );

    modport slave (
        input  in_v, add_out, out_rdy,
        output in_rdy, out_v, out_acc, out_last, busy
    );
endinterface

// File: rtl/mvu_pe_acc_seq.sv
// MVU processing-element accumulator sequencer.
// Counts SF adder beats per result, tracks each accepted beat through an
// ADD_LAT-deep valid/last delay line so its add_out is summed on arrival, and
// presents one result per SF beats with out_last on the NF-th result of a frame.
// Ports: clk, rst_n (synchronous, active-low), bus (mvu_pe_acc_seq_if.slave).
// Optional build macro MVU_PE_ACC_SAT_EN: saturate every addition to the signed
// TDstI range instead of wrapping.
module mvu_pe_acc_seq #(
    parameter int unsigned TDstI   = 16,
    parameter int unsigned SF      = 4,
    parameter int unsigned NF      = 2,
    parameter int unsigned ADD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    mvu_pe_acc_seq_if.slave   bus
);

    localparam int unsigned SF_W = (SF > 1) ? $clog2(SF) : 1;
    localparam int unsigned NF_W = (NF > 1) ? $clog2(NF) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t             state;
    logic [SF_W-1:0]    sf_iss;
    logic [SF_W-1:0]    sf_iss_nx;
    logic [SF_W-1:0]    sf_ret;
    logic [NF_W-1:0]    nf_idx;
    logic [NF_W-1:0]    nf_nx;
    logic [ADD_LAT-1:0] pipe_v;
    logic [ADD_LAT-1:0] pipe_last;
    logic [TDstI-1:0]   acc;
    logic               out_v_q;
    logic [TDstI-1:0]   out_acc_q;
    logic               out_last_q;

    logic               iss_last;
    logic               in_rdy_c;
    logic               beat_acc;
    logic               ret_v;
    logic               ret_last;
    logic               ret_first;
    logic               hs;
    logic [TDstI-1:0]   sum;
    logic [TDstI-1:0]   fin;

    // Single addition, wrapping or saturating depending on the build.
    function automatic logic [TDstI-1:0] acc_add(input logic [TDstI-1:0] a,
                                                 input logic [TDstI-1:0] b);
        logic [TDstI-1:0] s;
        s = a + b;
`ifdef MVU_PE_ACC_SAT_EN
        if ((a[TDstI-1] == b[TDstI-1]) && (s[TDstI-1] != a[TDstI-1]))
            s = a[TDstI-1] ? {1'b1, {(TDstI-1){1'b0}}} : {1'b0, {(TDstI-1){1'b1}}};
`endif
        return s;
    endfunction

    // Last beats are held back while the previous result is still in flight or
    // stalled in the output register, so a retiring sum always finds it free.
    assign iss_last  = (sf_iss == SF_W'(SF - 1));
    assign in_rdy_c  = rst_n && (!iss_last ||
                       ((state != DRAIN) && (!out_v_q || bus.out_rdy)));
    assign beat_acc  = bus.in_v && in_rdy_c;
    assign ret_v     = pipe_v[ADD_LAT-1];
    assign ret_last  = pipe_last[ADD_LAT-1];
    assign ret_first = (sf_ret == '0);
    assign hs        = out_v_q && bus.out_rdy;
    assign sum       = acc_add(acc, bus.add_out);
    assign fin       = ret_first ? bus.add_out : sum;

    // Next issue count and next result index.
    always_comb begin
        sf_iss_nx = sf_iss;
        nf_nx     = nf_idx;
        if (beat_acc)
            sf_iss_nx = iss_last ? '0 : sf_iss + SF_W'(1);
        if (hs)
            nf_nx = (nf_idx == NF_W'(NF - 1)) ? '0 : nf_idx + NF_W'(1);
    end

    // Issue FSM and beat counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            sf_iss <= '0;
        end else begin
            sf_iss <= sf_iss_nx;
            if (beat_acc && iss_last)
                state <= DRAIN;
            else if (state == DRAIN) begin
                if (ret_v && ret_last)
                    state <= (sf_iss_nx != '0) ? ISSUE : IDLE;
            end else
                state <= (sf_iss_nx != '0) ? ISSUE : IDLE;
        end
    end

    // Valid/last delay line matching the adder-tree latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_v    <= '0;
            pipe_last <= '0;
        end else begin
            pipe_v[0]    <= beat_acc;
            pipe_last[0] <= beat_acc && iss_last;
            for (int i = 1; i < int'(ADD_LAT); i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
        end
    end

    // Retire side: partial sum, output register and frame index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sf_ret     <= '0;
            acc        <= '0;
            nf_idx     <= '0;
            out_v_q    <= 1'b0;
            out_acc_q  <= '0;
            out_last_q <= 1'b0;
        end else begin
            nf_idx <= nf_nx;
            if (ret_v) begin
                sf_ret <= ret_last ? '0 : sf_ret + SF_W'(1);
                acc    <= ret_last ? '0 : fin;
            end
            if (ret_v && ret_last) begin
                out_v_q    <= 1'b1;
                out_acc_q  <= fin;
                out_last_q <= (nf_nx == NF_W'(NF - 1));
            end else if (hs) begin
                out_v_q    <= 1'b0;
                out_last_q <= 1'b0;
            end
        end
    end

    assign bus.in_rdy   = in_rdy_c;
    assign bus.out_v    = out_v_q;
    assign bus.out_acc  = out_acc_q;
    assign bus.out_last = out_last_q;
    assign bus.busy     = (state != IDLE) || (|pipe_v) || out_v_q;

endmodule

// File: tb/tb_mvu_pe_acc_seq.sv
// Scoreboard bench for mvu_pe_acc_seq: three instances
//   0: TDstI=16 SF=4 NF=2, 1: TDstI=16 SF=1 NF=2, 2: TDstI=8 SF=4 NF=2 (all ADD_LAT=2).
// A behavioural adder tree delays each accepted beat value by two cycles.
module tb_mvu_pe_acc_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_v    [3];
    logic [15:0] dat     [3];
    logic        out_rdy [3];
    logic [15:0] p1      [3];
    logic [15:0] p2      [3];
    logic        in_rdy_w[3];
    logic        o_v     [3];
    logic [15:0] o_acc   [3];
    logic        o_last  [3];
    logic        o_busy  [3];

    mvu_pe_acc_seq_if #(.TDstI(16)) ia ();
    mvu_pe_acc_seq_if #(.TDstI(16)) ib ();
    mvu_pe_acc_seq_if #(.TDstI(8))  ic ();

    mvu_pe_acc_seq #(.TDstI(16), .SF(4), .NF(2), .ADD_LAT(2)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
    mvu_pe_acc_seq #(.TDstI(16), .SF(1), .NF(2), .ADD_LAT(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
    mvu_pe_acc_seq #(.TDstI(8),  .SF(4), .NF(2), .ADD_LAT(2)) u_c (.clk(clk), .rst_n(rst_n), .bus(ic.slave));

    assign ia.in_v = in_v[0];  assign ia.out_rdy = out_rdy[0];  assign ia.add_out = p2[0];
    assign ib.in_v = in_v[1];  assign ib.out_rdy = out_rdy[1];  assign ib.add_out = p2[1];
    assign ic.in_v = in_v[2];  assign ic.out_rdy = out_rdy[2];  assign ic.add_out = p2[2][7:0];

    assign in_rdy_w[0] = ia.in_rdy;  assign o_v[0] = ia.out_v;  assign o_acc[0] = ia.out_acc;
    assign o_last[0]   = ia.out_last; assign o_busy[0] = ia.busy;
    assign in_rdy_w[1] = ib.in_rdy;  assign o_v[1] = ib.out_v;  assign o_acc[1] = ib.out_acc;
    assign o_last[1]   = ib.out_last; assign o_busy[1] = ib.busy;
    assign in_rdy_w[2] = ic.in_rdy;  assign o_v[2] = ic.out_v;
    assign o_acc[2]    = {{8{ic.out_acc[7]}}, ic.out_acc};
    assign o_last[2]   = ic.out_last; assign o_busy[2] = ic.busy;

    // Behavioural adder tree: beat value appears on add_out two cycles after acceptance.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            p1[i] <= (in_v[i] && in_rdy_w[i]) ? dat[i] : 16'hA5A5;
            p2[i] <= p1[i];
        end
    end

    typedef struct packed {
        logic [1:0]  idx;
        logic        last;
        logic [15:0] acc;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    // Monitor: pops an expected result on every handshake, checks hold-while-stalled.
    exp_t        e;
    logic        prev_v   [3];
    logic        prev_rdy [3];
    logic [15:0] prev_acc [3];
    logic        prev_last[3];
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_n && prev_v[i] && !prev_rdy[i]) begin
                n_chk++;
                if (!(o_v[i] && o_acc[i] == prev_acc[i] && o_last[i] == prev_last[i])) begin
                    n_err++;
                    $display("FAIL hold inst=%0d v=%b acc=%h last=%b required v=1 acc=%h last=%b",
                             i, o_v[i], o_acc[i], o_last[i], prev_acc[i], prev_last[i]);
                end
            end
            if (rst_n && o_v[i] && out_rdy[i]) begin
                n_chk++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_result inst=%0d acc=%h last=%b", i, o_acc[i], o_last[i]);
                end else begin
                    e = q.pop_front();
                    if (e.idx != 2'(i) || e.acc != o_acc[i] || e.last != o_last[i]) begin
                        n_err++;
                        $display("FAIL result inst=%0d acc=%h last=%b required inst=%0d acc=%h last=%b",
                                 i, o_acc[i], o_last[i], e.idx, e.acc, e.last);
                    end
                end
            end
            prev_v[i]    = o_v[i] && rst_n;
            prev_rdy[i]  = out_rdy[i];
            prev_acc[i]  = o_acc[i];
            prev_last[i] = o_last[i];
        end
    end

    task automatic chk1(input string name, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%b required=%b", name, got, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic push(input int i, input logic last, input logic [15:0] acc);
        exp_t t;
        t.idx  = 2'(i);
        t.last = last;
        t.acc  = acc;
        q.push_back(t);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Entered at posedge+1; waits for in_rdy, lets the next edge take the beat.
    task automatic issue_wait(input int i);
        bit ok = 1'b0;
        for (int b = 0; b < 100; b++) begin
            @(negedge clk);
            if (in_rdy_w[i]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            n_err++;
            $display("FAIL in_rdy_timeout inst=%0d got=0 required=1", i);
        end
        sync();
        in_v[i] = 1'b0;
    endtask

    task automatic send(input int i, input logic [15:0] v);
        in_v[i] = 1'b1;
        dat[i]  = v;
        issue_wait(i);
    endtask

    // out_v must rise exactly two edges after the last-beat acceptance edge.
    task automatic check_lat(input int i);
        @(negedge clk);
        @(negedge clk);
        chk1("lat_early", o_v[i], 1'b0);
        @(negedge clk);
        chk1("lat_due", o_v[i], 1'b1);
        sync();
    endtask

    task automatic wait_idle(input int i);
        bit ok = 1'b0;
        for (int b = 0; b < 100; b++) begin
            @(negedge clk);
            if (!o_busy[i] && q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            n_err++;
            $display("FAIL idle_timeout inst=%0d busy=%b pending=%0d required busy=0 pending=0",
                     i, o_busy[i], q.size());
        end
        sync();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_v[i] = 1'b0; dat[i] = 16'h0; out_rdy[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk1("rst_in_rdy", in_rdy_w[i], 1'b0);
            chk1("rst_out_v", o_v[i], 1'b0);
            chk1("rst_out_last", o_last[i], 1'b0);
            chk1("rst_busy", o_busy[i], 1'b0);
            chk16("rst_out_acc", o_acc[i], 16'h0);
        end
        sync();
        rst_n = 1'b1;

        // Two sets into one frame, free-running output.
        out_rdy[0] = 1'b1;
        push(0, 1'b0, 16'd10);
        send(0, 16'd1); send(0, 16'd2); send(0, 16'd3); send(0, 16'd4);
        check_lat(0);
        wait_idle(0);
        push(0, 1'b1, 16'd26);
        send(0, 16'd5); send(0, 16'd6); send(0, 16'd7); send(0, 16'd8);
        check_lat(0);
        wait_idle(0);
        chk1("idle_busy", o_busy[0], 1'b0);

        // Output stall: last beat of the second set is held off until out_rdy.
        out_rdy[0] = 1'b0;
        push(0, 1'b0, 16'd10);
        push(0, 1'b1, 16'd26);
        send(0, 16'd1); send(0, 16'd2); send(0, 16'd3); send(0, 16'd4);
        ok = 1'b0;
        for (int b = 0; b < 20; b++) begin
            @(negedge clk);
            if (o_v[0]) begin ok = 1'b1; break; end
        end
        chk1("stall_first_v", ok, 1'b1);
        sync();
        send(0, 16'd5); send(0, 16'd6); send(0, 16'd7);
        in_v[0] = 1'b1;
        dat[0]  = 16'd8;
        for (int b = 0; b < 6; b++) begin
            @(negedge clk);
            chk1("stall_last_rdy", in_rdy_w[0], 1'b0);
        end
        chk16("stall_held_acc", o_acc[0], 16'd10);
        sync();
        out_rdy[0] = 1'b1;
        @(negedge clk);
        chk1("release_rdy", in_rdy_w[0], 1'b1);
        sync();
        in_v[0] = 1'b0;
        wait_idle(0);

        // SF=1: every beat is last; second beat waits out the drain.
        out_rdy[1] = 1'b1;
        push(1, 1'b0, 16'd7);
        push(1, 1'b1, 16'd9);
        send(1, 16'd7);
        in_v[1] = 1'b1;
        dat[1]  = 16'd9;
        @(negedge clk);
        chk1("sf1_drain_rdy", in_rdy_w[1], 1'b0);
        chk1("sf1_busy", o_busy[1], 1'b1);
        issue_wait(1);
        wait_idle(1);

        // Reset mid-set discards partial sum and in-flight beats.
        send(0, 16'd50); send(0, 16'd60);
        rst_n = 1'b0;
        @(negedge clk);
        chk1("midrst_in_rdy", in_rdy_w[0], 1'b0);
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        chk1("midrst_out_v", o_v[0], 1'b0);
        chk16("midrst_out_acc", o_acc[0], 16'h0);
        chk1("midrst_out_last", o_last[0], 1'b0);
        chk1("midrst_busy", o_busy[0], 1'b0);
        @(negedge clk);
        chk1("midrst_busy2", o_busy[0], 1'b0);
        sync();
        push(0, 1'b0, 16'd4);
        send(0, 16'd1); send(0, 16'd1); send(0, 16'd1); send(0, 16'd1);
        wait_idle(0);

        // 8-bit overflow: wrap or saturate per addition.
        out_rdy[2] = 1'b1;
`ifdef MVU_PE_ACC_SAT_EN
        push(2, 1'b0, 16'h007F);
`else
        push(2, 1'b0, 16'hFFC8);
`endif
        send(2, 16'd100); send(2, 16'd100); send(2, 16'd0); send(2, 16'd0);
        wait_idle(2);
`ifdef MVU_PE_ACC_SAT_EN
        push(2, 1'b1, 16'hFF81);
`else
        push(2, 1'b1, 16'h0001);
`endif
        send(2, 16'h0080); send(2, 16'h0080); send(2, 16'd0); send(2, 16'd1);
        wait_idle(2);

        n_chk++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expected got=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
